// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: shares one pipelined single-precision multiplier between two
// requesters. Round-robin grant and one issue per cycle. A tag pipe follows
// each operation through the multiplier so that every product returns to the
// port that issued it. A saturating counter records overflowed products.
module fpmul_arbiter #(
  parameter int LATENCY = 3,   // multiplier latency in cycles, legal 1..8
  parameter int CNT_W   = 16   // width of the overflow event counter
) (
  input  logic             clock,
  input  logic             reset,        // asynchronous, active-low

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,

  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_result,
  input  logic             mul_overflow,

  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [31:0]      resp_data,
  output logic             resp_overflow,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_count
);

  // Entry 0 is the mul_start cycle. The multiplier samples one edge later
  // and holds its result LATENCY cycles after that. So the last entry
  // (index LATENCY+1) lines up with the cycle where mul_result is valid.
  localparam int DEPTH = LATENCY + 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic valid;
    logic id;      // originating port
  } tag_t;

  logic  last_grant;
  logic  grant0;
  logic  grant1;
  logic  busy_c;
  tag_t  tag_q [DEPTH];
  tag_t  tag_out;

  // Combinational round-robin grant. A sole requester always wins. Under
  // contention, the port that did not win last time wins.
  // NOTE: every signal in an always_comb gets a default assignment first.
  //       Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue stage: register the winning operands and pulse mul_start.
  // last_grant resets to 1, so port 0 wins the first contention.
  // NOTE: clocked state uses non-blocking (<=) assignments only. All
  //       registers then update together at the edge, and the block
  //       order does not matter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else if (grant0) begin
      last_grant <= 1'b0;
      mul_start  <= 1'b1;
      mul_a      <= req0_a;
      mul_b      <= req0_b;
    end else if (grant1) begin
      last_grant <= 1'b1;
      mul_start  <= 1'b1;
      mul_a      <= req1_a;
      mul_b      <= req1_b;
    end else begin
      mul_start  <= 1'b0;
    end
  end

  // Tag pipe: shift {valid, id} alongside the multiplier pipeline.
  // NOTE: this small register array is reset on purpose. Clearing the valid
  //       bits is what discards in-flight operations when reset asserts.
  //       Large data memories normally stay unreset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: grant0 | grant1, id: grant1};
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[DEPTH-1];

  // Response stage: capture the product and steer a one-cycle valid pulse
  // to the port named by the tag. Data holds between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
      resp_data     <= '0;
      resp_overflow <= 1'b0;
    end else if (tag_out.valid) begin
      resp0_valid   <= ~tag_out.id;
      resp1_valid   <= tag_out.id;
      resp_data     <= mul_result;
      resp_overflow <= mul_overflow;
    end else begin
      resp0_valid   <= 1'b0;
      resp1_valid   <= 1'b0;
    end
  end

  // Overflow counter: count responses that carry the overflow flag.
  // The counter saturates at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_count <= '0;
    end else if (tag_out.valid && mul_overflow && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_ONE;
    end
  end

  // Busy: something is in flight anywhere from mul_start to the result cycle.
  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_c = busy_c | tag_q[i].valid;
    end
  end

  assign busy = busy_c;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Testbench for fpmul_arbiter. Three instances (LATENCY 3, 1 and 8) share
// the same request stimulus. Each instance has its own multiplier model and
// a response scoreboard queue.
module tb_fpmul_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        ovf;
    int          due;
  } exp_t;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        r0;
    logic        r1;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic [31:0] a1 = '0;
  logic [31:0] b1 = '0;

  logic        r0    [N];
  logic        r1    [N];
  logic        ms    [N];
  logic [31:0] ma    [N];
  logic [31:0] mb    [N];
  logic [31:0] mres  [N];
  logic        movf  [N];
  logic        rv0   [N];
  logic        rv1   [N];
  logic [31:0] rdata [N];
  logic        rovf  [N];
  logic        bsy   [N];
  logic [15:0] ocnt  [N];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in for the multiplier datapath. 2.0*3.0 gives the real product.
  // Any other pair gives a scrambled but deterministic value.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
  endfunction

  function automatic logic ovf_fn(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) && (b != 32'hFFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 8);

    logic [31:0] pd [LAT+1];
    logic        po [LAT+1];
    exp_t        q [$];
    exp_t        e;
    logic [15:0] mcnt;

    fpmul_arbiter #(.LATENCY(LAT), .CNT_W(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .req0_valid   (v0),
      .req0_ready   (r0[g]),
      .req0_a       (a0),
      .req0_b       (b0),
      .req1_valid   (v1),
      .req1_ready   (r1[g]),
      .req1_a       (a1),
      .req1_b       (b1),
      .mul_start    (ms[g]),
      .mul_a        (ma[g]),
      .mul_b        (mb[g]),
      .mul_result   (mres[g]),
      .mul_overflow (movf[g]),
      .resp0_valid  (rv0[g]),
      .resp1_valid  (rv1[g]),
      .resp_data    (rdata[g]),
      .resp_overflow(rovf[g]),
      .busy         (bsy[g]),
      .ovf_count    (ocnt[g])
    );

    // Multiplier model: it samples operands at each edge. The result is
    // valid LAT cycles after that sampling edge.
    always @(posedge clock) begin
      pd[0] <= fmul_model(ma[g], mb[g]);
      po[0] <= ovf_fn(ma[g], mb[g]);
      for (int i = 1; i <= LAT; i++) begin
        pd[i] <= pd[i-1];
        po[i] <= po[i-1];
      end
    end

    assign mres[g] = pd[LAT];
    assign movf[g] = po[LAT];

    // Scoreboard: an accept seen at this negedge happens at the next edge.
    // Its response must be visible LAT+2 edges after that.
    always @(negedge clock) begin
      if (!reset) begin
        q.delete();
        mcnt = '0;
      end else begin
        if (rv0[g] || rv1[g]) begin
          check($sformatf("L%0d resp_both", LAT), {31'd0, rv0[g] & rv1[g]}, 32'd0);
          if (q.size() == 0) begin
            check($sformatf("L%0d unexpected_resp", LAT), {31'd0, rv0[g] | rv1[g]}, 32'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("L%0d resp_port", LAT), {31'd0, rv1[g]}, {31'd0, e.port});
            check($sformatf("L%0d resp_data", LAT), rdata[g], e.data);
            check($sformatf("L%0d resp_ovf", LAT), {31'd0, rovf[g]}, {31'd0, e.ovf});
            check($sformatf("L%0d resp_cycle", LAT), cyc, e.due);
            if (e.ovf && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
          end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
          check($sformatf("L%0d missing_resp", LAT), {31'd0, rv0[g] | rv1[g]}, 32'd1);
          void'(q.pop_front());
        end
        check($sformatf("L%0d busy", LAT), {31'd0, bsy[g]}, {31'd0, q.size() != 0});
        check($sformatf("L%0d ovf_count", LAT), {16'd0, ocnt[g]}, {16'd0, mcnt});
        check($sformatf("L%0d ready_both", LAT), {31'd0, r0[g] & r1[g]}, 32'd0);
        if (v0 && r0[g]) q.push_back('{1'b0, fmul_model(a0, b0), ovf_fn(a0, b0), cyc + LAT + 3});
        if (v1 && r1[g]) q.push_back('{1'b1, fmul_model(a1, b1), ovf_fn(a1, b1), cyc + LAT + 3});
      end
    end
  end

  function automatic vec_t mk(input logic v0_i, input logic v1_i, input logic r0_i, input logic r1_i);
    vec_t v;
    v.v0 = v0_i;
    v.v1 = v1_i;
    v.a0 = $urandom;
    v.b0 = $urandom;
    v.a1 = $urandom;
    v.b1 = $urandom;
    v.r0 = r0_i;
    v.r1 = r1_i;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clock);
    #1;
    v0    = 1'b0;
    v1    = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [15];
    int   k;

    // Grant sequence from reset (last_grant = 1). Six contention cycles
    // alternate 0,1,0,1,0,1. Then idle, sole requesters, and mixed cases.
    tbl[0]  = mk(1, 1, 1, 0);
    tbl[1]  = mk(1, 1, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0);
    tbl[3]  = mk(1, 1, 0, 1);
    tbl[4]  = mk(1, 1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1);
    tbl[8]  = mk(0, 1, 0, 1);
    tbl[9]  = mk(1, 1, 1, 0);
    tbl[10] = mk(1, 0, 1, 0);
    tbl[11] = mk(1, 0, 1, 0);
    tbl[12] = mk(1, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, 0);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("reset_flags_%0d", g),
            {25'd0, ms[g], rv0[g], rv1[g], rovf[g], bsy[g], r0[g], r1[g]}, 32'd0);
      check($sformatf("reset_mul_a_%0d", g), ma[g], 32'd0);
      check($sformatf("reset_ovf_count_%0d", g), {16'd0, ocnt[g]}, 32'd0);
    end
    @(posedge clock);
    #3;
    reset = 1'b1;

    // Single request: 2.0 * 3.0 on port 0.
    @(posedge clock);
    #1;
    v0 = 1'b1;
    a0 = 32'h4000_0000;
    b0 = 32'h4040_0000;
    @(negedge clock);
    for (int g = 0; g < N; g++) begin
      check($sformatf("single_ready0_%0d", g), {31'd0, r0[g]}, 32'd1);
      check($sformatf("single_ready1_%0d", g), {31'd0, r1[g]}, 32'd0);
    end
    @(posedge clock);
    #1;
    v0 = 1'b0;
    for (int g = 0; g < N; g++) begin
      check($sformatf("single_start_%0d", g), {31'd0, ms[g]}, 32'd1);
      check($sformatf("single_mul_a_%0d", g), ma[g], 32'h4000_0000);
      check($sformatf("single_mul_b_%0d", g), mb[g], 32'h4040_0000);
    end
    @(posedge clock);
    #1;
    check("single_start_pulse", {31'd0, ms[0]}, 32'd0);
    k = 1;
    while (!rv0[0] && k < 20) begin
      check("single_no_resp1", {31'd0, rv1[0]}, 32'd0);
      @(posedge clock);
      #1;
      k++;
    end
    check("single_latency", k, 32'd5);
    check("single_data", rdata[0], 32'h40C0_0000);
    check("single_resp1_quiet", {31'd0, rv1[0]}, 32'd0);
    repeat (12) @(posedge clock);

    // Table-driven grant vectors from a fresh reset.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      v0 = tbl[i].v0;
      v1 = tbl[i].v1;
      a0 = tbl[i].a0;
      b0 = tbl[i].b0;
      a1 = tbl[i].a1;
      b1 = tbl[i].b1;
      @(negedge clock);
      for (int g = 0; g < N; g++) begin
        check($sformatf("tbl%0d_ready0_%0d", i, g), {31'd0, r0[g]}, {31'd0, tbl[i].r0});
        check($sformatf("tbl%0d_ready1_%0d", i, g), {31'd0, r1[g]}, {31'd0, tbl[i].r1});
      end
    end
    @(posedge clock);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (14) @(posedge clock);

    // Random valid patterns. The scoreboards check every response.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = $urandom;
      b0 = $urandom;
      a1 = $urandom;
      b1 = $urandom;
    end
    @(posedge clock);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (14) @(posedge clock);

    // Reset with three operations in flight.
    @(posedge clock);
    #1;
    v0 = 1'b1;
    v1 = 1'b1;
    a0 = 32'h3F80_0000;
    b0 = 32'h4000_0000;
    a1 = 32'h4080_0000;
    b1 = 32'h4100_0000;
    repeat (3) @(posedge clock);
    #2;
    v0    = 1'b0;
    v1    = 1'b0;
    reset = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("midrst_flags_%0d", g),
            {25'd0, ms[g], rv0[g], rv1[g], rovf[g], bsy[g], r0[g], r1[g]}, 32'd0);
      check($sformatf("midrst_mul_a_%0d", g), ma[g], 32'd0);
      check($sformatf("midrst_mul_b_%0d", g), mb[g], 32'd0);
      check($sformatf("midrst_resp_data_%0d", g), rdata[g], 32'd0);
      check($sformatf("midrst_ovf_count_%0d", g), {16'd0, ocnt[g]}, 32'd0);
    end
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    v0 = 1'b1;
    v1 = 1'b1;
    @(negedge clock);
    for (int g = 0; g < N; g++) begin
      check($sformatf("postrst_ready0_%0d", g), {31'd0, r0[g]}, 32'd1);
      check($sformatf("postrst_ready1_%0d", g), {31'd0, r1[g]}, 32'd0);
    end
    @(posedge clock);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (14) @(posedge clock);

    // Overflow on every product. 70000 back-to-back operations saturate the
    // counter.
    #1;
    v0 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      a0 = 32'h7F80_0000 | (i & 32'h007F_FFFF);
      b0 = i;
      @(posedge clock);
      #1;
    end
    v0 = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < N; g++) begin
      check($sformatf("saturated_%0d", g), {16'd0, ocnt[g]}, 32'h0000_FFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
